// File: rtl/cxl_axi_wr_responder.sv
// -----------------------------------------------------------------------------
// cxl_axi_wr_responder
//
// AXI4 write-slave responder standing in for the CXL IP write path on
// axi4_mm_clk. Write bursts are absorbed (data discarded). One B response is
// returned per burst, with IDs in strict AW order.
//
// Structure:
//   - AW queue  : {awid, awlen} per accepted address, OUTST_DEPTH entries.
//   - W binding : beats always belong to the AW queue head. The burst completes
//                 on beat awlen. wlast is only checked, never used to terminate.
//   - B queue   : {id, resp, release timestamp}, OUTST_DEPTH entries.
//   - Optional periodic AW/W back-pressure. awready/wready are registered.
//   - Traffic statistics and a sticky protocol error flag.
//
// Optional feature macro: CXL_AXI_WR_RSP_ERR_INJ_EN
//   When defined, an err_inj input is added. Any burst that completes while
//   err_inj=1 gets bresp=SLVERR. protocol_err is not affected by err_inj.
//
// Ports:
//   axi4_mm_clk, axi4_mm_rst       clock, async active-high reset
//   err_inj                        (macro only) force SLVERR on completing bursts
//   awid/awaddr/awlen/awvalid/awready   write address channel
//   wdata/wstrb/wlast/wvalid/wready     write data channel (data discarded)
//   bid/bresp/bvalid/bready             write response channel
//   stat_bursts                    completed B handshakes (wraps)
//   stat_beats                     accepted W beats (wraps)
//   stat_outst                     bursts with AW accepted but no B handshake yet
//   stat_last_addr                 awaddr of the most recent AW handshake
//   protocol_err                   sticky wlast-mismatch flag
// -----------------------------------------------------------------------------
module cxl_axi_wr_responder #(
  parameter int ID_W            = 8,
  parameter int ADDR_W          = 64,
  parameter int DATA_W          = 512,
  parameter int OUTST_DEPTH     = 8,
  parameter int AW_STALL_PERIOD = 0,
  parameter int W_STALL_PERIOD  = 0,
  parameter int B_LATENCY       = 1
) (
  input  logic                           axi4_mm_clk,
  input  logic                           axi4_mm_rst,
`ifdef CXL_AXI_WR_RSP_ERR_INJ_EN
  input  logic                           err_inj,
`endif
  input  logic [ID_W-1:0]                awid,
  input  logic [ADDR_W-1:0]              awaddr,
  input  logic [7:0]                     awlen,
  input  logic                           awvalid,
  output logic                           awready,
  input  logic [DATA_W-1:0]              wdata,
  input  logic [DATA_W/8-1:0]            wstrb,
  input  logic                           wlast,
  input  logic                           wvalid,
  output logic                           wready,
  output logic [ID_W-1:0]                bid,
  output logic [1:0]                     bresp,
  output logic                           bvalid,
  input  logic                           bready,
  output logic [31:0]                    stat_bursts,
  output logic [31:0]                    stat_beats,
  output logic [$clog2(OUTST_DEPTH):0]   stat_outst,
  output logic [ADDR_W-1:0]              stat_last_addr,
  output logic                           protocol_err
);

  localparam int PTR_W = $clog2(OUTST_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] QUEUE_FULL    = CNT_W'(OUTST_DEPTH);
  // stat_outst is only CNT_W bits wide. Holding back its top code keeps the
  // count representable, so it never wraps.
  localparam logic [CNT_W-1:0] OUTST_MAX     = {CNT_W{1'b1}};
  localparam logic [15:0]      B_LAT         = 16'(B_LATENCY);
  localparam logic [31:0]      AW_STALL_LAST = 32'(AW_STALL_PERIOD - 1);
  localparam logic [31:0]      W_STALL_LAST  = 32'(W_STALL_PERIOD - 1);
  localparam logic [1:0]       RESP_OKAY     = 2'b00;
  localparam logic [1:0]       RESP_SLVERR   = 2'b10;

  // ---------------------------------------------------------------------------
  // Error injection source
  // ---------------------------------------------------------------------------
  logic inj;
`ifdef CXL_AXI_WR_RSP_ERR_INJ_EN
  assign inj = err_inj;
`else
  assign inj = 1'b0;
`endif

  // Write data and strobes are sunk without being inspected.
  logic unused_data;
  assign unused_data = ^{wdata, wstrb};

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [ID_W-1:0]  aw_id_mem  [OUTST_DEPTH];
  logic [7:0]       aw_len_mem [OUTST_DEPTH];
  logic [PTR_W-1:0] aw_wr_ptr, aw_rd_ptr;
  logic [CNT_W-1:0] aw_cnt, aw_cnt_next;

  logic [ID_W-1:0]  b_id_mem   [OUTST_DEPTH];
  logic [1:0]       b_resp_mem [OUTST_DEPTH];
  logic [15:0]      b_ts_mem   [OUTST_DEPTH];
  logic [PTR_W-1:0] b_wr_ptr, b_rd_ptr;
  logic [CNT_W-1:0] b_cnt, b_cnt_next;
  logic             b_held;

  logic [7:0]       beat_cnt;
  logic             bad_acc;
  logic [15:0]      cycle_cnt;

  logic [31:0]      aw_stall_cnt, aw_stall_cnt_next;
  logic [31:0]      w_stall_cnt,  w_stall_cnt_next;
  logic             aw_stall_next, w_stall_next;

  logic [CNT_W-1:0] outst_next;

  // ---------------------------------------------------------------------------
  // Handshakes and burst tracking
  // ---------------------------------------------------------------------------
  logic       aw_hs, w_hs, b_hs;
  logic [7:0] head_len;
  logic       beat_final, wlast_bad, burst_done, burst_bad;
  logic [15:0] b_age;
  logic       b_due;

  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid  && wready;
  assign b_hs  = bvalid  && bready;

  // wready is only ever high with a non-empty AW queue, so the head is valid
  // whenever a beat is accepted.
  assign head_len   = aw_len_mem[aw_rd_ptr];
  assign beat_final = (beat_cnt == head_len);
  assign wlast_bad  = (wlast != beat_final);
  assign burst_done = w_hs && beat_final;
  assign burst_bad  = bad_acc || wlast_bad || inj;

  // Release test: the head is due once cycle_cnt has reached its timestamp,
  // judged on the signed 16-bit difference so counter wrap is harmless.
  assign b_age = cycle_cnt - b_ts_mem[b_rd_ptr];
  assign b_due = !b_age[15];

  // b_held keeps bvalid asserted once presented, independent of how long the
  // master stalls.
  assign bvalid = (b_cnt != '0) && (b_held || b_due);
  assign bid    = bvalid ? b_id_mem[b_rd_ptr]   : '0;
  assign bresp  = bvalid ? b_resp_mem[b_rd_ptr] : RESP_OKAY;

  // ---------------------------------------------------------------------------
  // Next-state occupancy and stall decisions
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned in always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    aw_cnt_next = aw_cnt;
    b_cnt_next  = b_cnt;
    outst_next  = stat_outst;

    case ({aw_hs, burst_done})
      2'b10:   aw_cnt_next = aw_cnt + 1'b1;
      2'b01:   aw_cnt_next = aw_cnt - 1'b1;
      default: aw_cnt_next = aw_cnt;
    endcase

    case ({burst_done, b_hs})
      2'b10:   b_cnt_next = b_cnt + 1'b1;
      2'b01:   b_cnt_next = b_cnt - 1'b1;
      default: b_cnt_next = b_cnt;
    endcase

    case ({aw_hs, b_hs})
      2'b10:   outst_next = stat_outst + 1'b1;
      2'b01:   outst_next = stat_outst - 1'b1;
      default: outst_next = stat_outst;
    endcase
  end

  // Each stall counter counts handshakes on its channel. The handshake that
  // reaches PERIOD forces the ready low for the following cycle and restarts
  // the count.
  always_comb begin
    aw_stall_cnt_next = aw_stall_cnt;
    aw_stall_next     = 1'b0;
    if (AW_STALL_PERIOD != 0 && aw_hs) begin
      if (aw_stall_cnt == AW_STALL_LAST) begin
        aw_stall_cnt_next = '0;
        aw_stall_next     = 1'b1;
      end else begin
        aw_stall_cnt_next = aw_stall_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    w_stall_cnt_next = w_stall_cnt;
    w_stall_next     = 1'b0;
    if (W_STALL_PERIOD != 0 && w_hs) begin
      if (w_stall_cnt == W_STALL_LAST) begin
        w_stall_cnt_next = '0;
        w_stall_next     = 1'b1;
      end else begin
        w_stall_cnt_next = w_stall_cnt + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Control registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of process ordering.
  always_ff @(posedge axi4_mm_clk or posedge axi4_mm_rst) begin
    if (axi4_mm_rst) begin
      aw_wr_ptr      <= '0;
      aw_rd_ptr      <= '0;
      aw_cnt         <= '0;
      b_wr_ptr       <= '0;
      b_rd_ptr       <= '0;
      b_cnt          <= '0;
      b_held         <= 1'b0;
      beat_cnt       <= '0;
      bad_acc        <= 1'b0;
      cycle_cnt      <= '0;
      aw_stall_cnt   <= '0;
      w_stall_cnt    <= '0;
      awready        <= 1'b0;
      wready         <= 1'b0;
      stat_bursts    <= '0;
      stat_beats     <= '0;
      stat_outst     <= '0;
      stat_last_addr <= '0;
      protocol_err   <= 1'b0;
    end else begin
      cycle_cnt    <= cycle_cnt + 1'b1;
      aw_cnt       <= aw_cnt_next;
      b_cnt        <= b_cnt_next;
      stat_outst   <= outst_next;
      aw_stall_cnt <= aw_stall_cnt_next;
      w_stall_cnt  <= w_stall_cnt_next;
      b_held       <= bvalid && !bready;

      // Readies look at next-cycle occupancy, so a same-cycle pop frees a slot
      // immediately and a final beat always has a B slot waiting for it.
      awready <= (aw_cnt_next != QUEUE_FULL) && (outst_next != OUTST_MAX) &&
                 !aw_stall_next;
      wready  <= (aw_cnt_next != '0) && (b_cnt_next != QUEUE_FULL) &&
                 !w_stall_next;

      if (aw_hs) begin
        aw_wr_ptr      <= aw_wr_ptr + 1'b1;
        stat_last_addr <= awaddr;
      end

      if (w_hs) begin
        stat_beats <= stat_beats + 1'b1;
        if (wlast_bad) begin
          protocol_err <= 1'b1;
        end
        if (beat_final) begin
          beat_cnt  <= '0;
          bad_acc   <= 1'b0;
          aw_rd_ptr <= aw_rd_ptr + 1'b1;
          b_wr_ptr  <= b_wr_ptr + 1'b1;
        end else begin
          beat_cnt <= beat_cnt + 1'b1;
          bad_acc  <= bad_acc || wlast_bad;
        end
      end

      if (b_hs) begin
        b_rd_ptr    <= b_rd_ptr + 1'b1;
        stat_bursts <= stat_bursts + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Queue storage
  // ---------------------------------------------------------------------------
  // NOTE: queue storage has no reset; an entry is only read after it has been
  // written, and the reset pointers/counts already define the queues as empty.
  always_ff @(posedge axi4_mm_clk) begin
    if (aw_hs) begin
      aw_id_mem[aw_wr_ptr]  <= awid;
      aw_len_mem[aw_wr_ptr] <= awlen;
    end
    if (burst_done) begin
      b_id_mem[b_wr_ptr]   <= aw_id_mem[aw_rd_ptr];
      b_resp_mem[b_wr_ptr] <= burst_bad ? RESP_SLVERR : RESP_OKAY;
      b_ts_mem[b_wr_ptr]   <= cycle_cnt + B_LAT;
    end
  end

endmodule
